// File: rtl/noc_port_arbiter_if.sv
// Handshake bundle between the input-buffer FIFOs, the output-port arbiter
// and the downstream FIFO. The master side is the router fabric around the
// arbiter; the slave side is the arbiter itself.
interface noc_port_arbiter_if #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_INPUTS-1:0]            in_valid;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data;
    logic [NUM_INPUTS-1:0]            in_pop;
    logic                             out_valid;
    logic [DATA_WIDTH-1:0]            out_data;
    logic                             out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_pop, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_pop, out_valid, out_data
    );
endinterface

// File: rtl/noc_port_arbiter.sv
// Wormhole output-port arbiter: shares one output link among NUM_INPUTS
// input FIFOs, granting by round-robin at packet granularity and holding the
// grant until the packet's tail flit has been transferred.
module noc_port_arbiter #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    noc_port_arbiter_if.slave     bus,
    output logic [NUM_INPUTS-1:0] grant,
    output logic                  busy,
    output logic                  proto_err,
    output logic [CNT_WIDTH-1:0]  pkt_count
);
    localparam int PTR_WIDTH = $clog2(NUM_INPUTS);

    typedef enum logic {IDLE, BUSY} state_t;

    typedef enum logic [1:0] {
        FLIT_SINGLE = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_BODY   = 2'b10,
        FLIT_TAIL   = 2'b11
    } flit_type_t;

    // Input index base+off, wrapped into 0..NUM_INPUTS-1 (off < NUM_INPUTS).
    function automatic logic [PTR_WIDTH-1:0] wrap_add(input logic [PTR_WIDTH-1:0] base,
                                                      input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_INPUTS) sum = sum - NUM_INPUTS;
        return PTR_WIDTH'(sum);
    endfunction

    state_t                 state_q, state_d;
    logic [NUM_INPUTS-1:0]  grant_d;
    logic [PTR_WIDTH-1:0]   owner_q, owner_d;
    logic [PTR_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic                   first_flit_q, first_flit_d;
    logic                   proto_err_d;
    logic [CNT_WIDTH-1:0]   pkt_count_d;

    flit_type_t             front_type [NUM_INPUTS];
    logic [NUM_INPUTS-1:0]  eligible;
    logic [NUM_INPUTS-1:0]  stray;
    logic                   winner_found;
    logic [PTR_WIDTH-1:0]   winner;

    logic [DATA_WIDTH-1:0]  owner_data;
    flit_type_t             owner_type;
    logic                   owner_valid;
    logic                   active;
    logic                   xfer;
    logic                   last_flit;
    logic                   bad_flit;

    // A front flit may open a packet only if it is HEAD or SINGLE; a valid
    // BODY/TAIL at the front of an idle port is a stray continuation flit.
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_classify
        assign front_type[i] = flit_type_t'(bus.in_data[i*DATA_WIDTH + DATA_WIDTH-2 +: 2]);
        assign eligible[i]   = bus.in_valid[i] &&
                               (front_type[i] == FLIT_SINGLE || front_type[i] == FLIT_HEAD);
        assign stray[i]      = bus.in_valid[i] && !eligible[i];
    end

    // Round-robin search: first eligible input at or above rr_ptr, with wrap.
    always_comb begin
        winner_found = 1'b0;
        winner       = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (!winner_found && eligible[wrap_add(rr_ptr_q, k)]) begin
                winner_found = 1'b1;
                winner       = wrap_add(rr_ptr_q, k);
            end
        end
    end

    // The owner's FIFO front drives the link directly. Reset blocks any
    // transfer so an abandoned packet keeps its remaining flits queued.
    assign owner_valid = bus.in_valid[owner_q];
    assign owner_data  = bus.in_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
    assign owner_type  = flit_type_t'(owner_data[DATA_WIDTH-1 -: 2]);
    assign active      = (state_q == BUSY) && !rst;
    assign xfer        = active && owner_valid && bus.out_ready;
    assign last_flit   = (owner_type == FLIT_TAIL) || (owner_type == FLIT_SINGLE);
    assign bad_flit    = !first_flit_q &&
                         ((owner_type == FLIT_HEAD) || (owner_type == FLIT_SINGLE));

    assign bus.out_valid = active && owner_valid;
    assign bus.out_data  = active ? owner_data : '0;
    assign busy          = (state_q == BUSY);

    // One-hot pop to the owner's FIFO on every accepted flit.
    always_comb begin
        bus.in_pop = '0;
        if (xfer) bus.in_pop[owner_q] = 1'b1;
    end

    // Next-state logic: arbitrate while idle, release the port on the tail.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path through it infers a latch.
        state_d      = state_q;
        grant_d      = grant;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        first_flit_d = first_flit_q;
        pkt_count_d  = pkt_count;
        proto_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                proto_err_d = |stray;
                if (winner_found) begin
                    state_d          = BUSY;
                    grant_d          = '0;
                    grant_d[winner]  = 1'b1;
                    owner_d          = winner;
                    first_flit_d     = 1'b1;
                end
            end
            BUSY: begin
                if (xfer) begin
                    first_flit_d = 1'b0;
                    proto_err_d  = bad_flit;
                    if (last_flit) begin
                        state_d     = IDLE;
                        grant_d     = '0;
                        rr_ptr_d    = wrap_add(owner_q, 1);
                        pkt_count_d = pkt_count + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q      <= IDLE;
            grant        <= '0;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            first_flit_q <= 1'b0;
            pkt_count    <= '0;
            proto_err    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant        <= grant_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            first_flit_q <= first_flit_d;
            pkt_count    <= pkt_count_d;
            proto_err    <= proto_err_d;
        end
    end
endmodule

// File: doc/noc_port_arbiter.md
Name: noc_port_arbiter

Overview:
- Wormhole output-port arbiter for the router. It shares one output link among NUM_INPUTS input-buffer FIFOs.
- Each FIFO presents its front flit through asynchronous read, with in_valid = ~empty and in_pop driving rd_en.
- The arbiter picks one input by round-robin at packet granularity. It holds that input until the packet's tail flit has been transferred.
- Downstream readiness comes from the next stage's ~full.

Parameters:
- NUM_INPUTS, 4, number of requesting input FIFOs (2..8).
- DATA_WIDTH, 32, flit width. Bits [DATA_WIDTH-1:DATA_WIDTH-2] carry the flit type.
- CNT_WIDTH, 16, width of the completed-packet counter.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  NUM_INPUTS  bit i = input FIFO i non-empty.
- in_data  input  NUM_INPUTS*DATA_WIDTH  front flit of each FIFO; input i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- in_pop  output  NUM_INPUTS  one-hot pop (rd_en) to input FIFO i.
- out_valid  output  1  flit valid on the output link.
- out_data  output  DATA_WIDTH  flit to the downstream FIFO din.
- out_ready  input  1  downstream can accept a flit (~full).
- grant  output  NUM_INPUTS  one-hot registered owner of the output; 0 when idle.
- busy  output  1  a packet is in progress (state BUSY).
- proto_err  output  1  one-cycle pulse on a flit-type protocol violation.
- pkt_count  output  CNT_WIDTH  completed packets, wraps modulo 2^CNT_WIDTH.

Behaviour:
- Flit types (top 2 bits): 00 = SINGLE (head and tail), 01 = HEAD, 10 = BODY, 11 = TAIL.
- Reset (rst=1 at posedge): state IDLE, grant=0, rr_ptr=0, pkt_count=0, proto_err=0. Combinational outputs follow: in_pop=0, out_valid=0, out_data=0.
- Reset mid-packet abandons the packet. No pop occurs in the reset cycle, and the remaining flits stay in their FIFOs.
- State IDLE:
  - Eligible inputs are those with in_valid[i]=1 and type HEAD or SINGLE.
  - Search from rr_ptr upward with wrap; the first eligible input wins.
  - At posedge, grant <= onehot(winner) and state <= BUSY.
  - No flit moves in the IDLE cycle, so the head flit costs 1 cycle of arbitration latency.
  - An input with in_valid=1 and type BODY or TAIL at its front while IDLE is ineligible. proto_err pulses for 1 cycle (registered, the cycle after detection) and repeats every IDLE cycle while the condition persists.
  - The arbiter never discards flits.
- State BUSY (owner g):
  - out_valid = in_valid[g]; out_data = in_data slice g.
  - Transfer condition: xfer = in_valid[g] & out_ready. in_pop[g] = xfer; all other in_pop bits are 0.
  - On xfer with type TAIL or SINGLE: state <= IDLE, grant <= 0, rr_ptr <= (g+1) mod NUM_INPUTS, pkt_count <= pkt_count+1.
  - On xfer with type HEAD while BUSY, or type SINGLE other than as the first flit: the flit is still transferred and proto_err pulses.
  - If in_valid[g]=0 (bubble inside the packet), hold the grant and wait indefinitely.
  - If out_ready=0, hold; no pop and no state change.
- Output when not BUSY: out_valid=0 and out_data=0.
- First-flit tracking: a registered first_flit bit is set on entry to BUSY and cleared after the first xfer. A SINGLE flit is legal only when first_flit=1.
- Throughput: 1 flit/cycle inside a packet. Packet-to-packet gap is 1 idle cycle for arbitration.
- Fairness: after input g completes, g has lowest priority. An input with an eligible head waits at most NUM_INPUTS-1 packets.
- Combinational paths: in_valid/in_data/out_ready to in_pop/out_valid/out_data, with no loop through in_pop. grant, busy, pkt_count and proto_err are registered.

Test Plan:
- Reset, then input 2 presents a SINGLE flit 0x0000_00AA with out_ready=1 → grant=0100 at cycle 1, out_valid with out_data=0x0000_00AA and in_pop[2]=1 at cycle 1, IDLE at cycle 2, pkt_count=1.
- Inputs 0 and 1 each present a 3-flit packet (HEAD, BODY, TAIL), rr_ptr=0 → input 0's flits appear in 3 consecutive cycles, then 1 idle cycle, then input 1's three flits; no interleaving; pkt_count=2; rr_ptr=2.
- out_ready is low for 4 cycles mid-packet → out_data held stable, in_pop=0 throughout, no flit lost or duplicated, packet completes after out_ready returns.
- Owner's in_valid drops for 2 cycles after the BODY flit while input 3 has a pending HEAD → grant stays with the owner, input 3 is not served until the owner's TAIL transfers.
- Input 1 presents a BODY flit while IDLE and no other input requests → proto_err pulses every IDLE cycle, in_pop=0, grant=0.
- rst asserted on the cycle after a HEAD transfer → next cycle grant=0, busy=0, pkt_count=0; the remaining BODY/TAIL flits at the FIFO front then raise proto_err.
